my_dmux_16_4_way_buf: RTL and testbench
=======================================

MY_DMUX_16_4_WAY_BUF -- requirements
Module: my_dmux_16_4_way_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port in, input, WIDTH, the data word to dispatch.
REQ-005 The block SHALL have port sel, input, 2, the destination channel (0=a, 1=b, 2=c, 3=d).
REQ-006 The block SHALL have port in_valid, input, 1, meaning in/sel carry a word this cycle.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the selected channel accepts the word this cycle.
REQ-008 The block SHALL have ports a, b, c, d, output, WIDTH each, the per-channel holding registers.
REQ-009 The block SHALL have port out_valid, output, 4, where bit i means channel i (0=a ... 3=d) holds an undelivered word.
REQ-010 The block SHALL have port out_ready, input, 4, where bit i means the consumer of channel i takes its word this cycle.
REQ-011 The block SHALL have port count, output, 16, the running total of words accepted on the input.

Function
REQ-012 Each channel SHALL be a one-entry buffer: a full flag (driven on out_valid[i]) plus a WIDTH-bit data register (driven on a/b/c/d).
REQ-013 in_ready SHALL be combinational: !full[sel] || out_ready[sel].
- depends only on sel, full and out_ready; never on in_valid.
REQ-014 An input transfer SHALL occur when in_valid && in_ready are both high at a rising edge.
REQ-015 Channel i SHALL deliver a word when out_valid[i] && out_ready[i] are both high at a rising edge.
REQ-016 On an input transfer to channel i, data register i SHALL load in and full[i] SHALL be 1 from the next cycle: one-cycle latency.
REQ-017 Same-cycle delivery and refill of the same channel SHALL be supported: data register takes the new word and full[i] stays 1, with no bubble.
REQ-018 On a delivery without a refill, full[i] SHALL clear.
- the data register SHALL hold its last value; it is not cleared.
REQ-019 Channels not addressed by sel SHALL be unaffected by the input transfer.
- each channel drains independently and concurrently.
REQ-020 No word SHALL ever be dropped or duplicated.
- a full channel with out_ready[i]=0 back-pressures the input only when sel=i.
REQ-021 count SHALL increment by 1 on each input transfer and wrap from 16'hFFFF to 16'h0000.
REQ-022 out_ready bits for empty channels SHALL be ignored.
REQ-023 in and sel SHALL be ignored when in_valid=0.
REQ-024 The block SHALL produce no X on any output after reset, regardless of input timing.

Reset
REQ-025 While rst_n=0, out_valid SHALL be 4'b0000, a/b/c/d SHALL be 0, and count SHALL be 0, taking effect asynchronously without a clock edge.
REQ-026 Assertion of rst_n mid-operation SHALL discard all buffered words immediately.
- in_ready then evaluates to 1 for any sel.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising clk edge.
- the first transfer is possible on that edge when in_valid=1.

Verification
REQ-028 Reset then in=16'h1234, sel=2, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=4'b0100, c=16'h1234, count=1, in_ready=1 for sel=0/1/3 and 0 for sel=2.
REQ-029 Channel b full with out_ready[1]=1, in=16'hBEEF, sel=1, in_valid=1 -> same edge delivers old word and loads 16'hBEEF, out_valid[1] stays 1, count increments.
REQ-030 Round-robin sel=0,1,2,3 with words 16'h000A..16'h000D, out_ready=4'b0000 -> after 4 cycles out_valid=4'b1111, a..d = A..D; a fifth word to any sel sees in_ready=0, and count stays 4.
REQ-031 Preload count to 16'hFFFF via 65535 transfers with out_ready=4'b1111, one more transfer -> count=16'h0000.
REQ-032 With all channels full, assert rst_n=0 between clock edges -> out_valid=0, a..d=0 and count=0 immediately; after release the first word is accepted on the next edge.
REQ-033 Random in_valid/sel/out_ready for 10k cycles against a scoreboard -> per-channel delivery order and data match acceptance order exactly, and the total delivered plus still-full entries equals count.

Source files
------------

// File: rtl/my_dmux_16_4_way_buf.sv
// rtl/my_dmux_16_4_way_buf.sv - 1-to-4 demux with a one-entry buffer per channel
// Each channel holds one word until its consumer takes it; count tallies accepted input words.
module my_dmux_16_4_way_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [15:0]      count
);

  logic [3:0]       full;
  logic [WIDTH-1:0] data [4];
  logic             xfer;
  logic [3:0]       load;
  logic [3:0]       deliver;

  // A full channel can still take a word when its consumer drains it on the same edge.
  assign in_ready = !full[sel] || out_ready[sel];
  assign xfer     = in_valid && in_ready;
  assign deliver  = full & out_ready;

  always_comb begin
    load = 4'b0000;
    if (xfer) load[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 4'b0000;
      count <= 16'h0000;
      for (int i = 0; i < 4; i++) data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data[i] <= in;
          full[i] <= 1'b1;
        end else if (deliver[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (xfer) count <= count + 16'd1;
    end
  end

  assign out_valid = full;
  assign a         = data[0];
  assign b         = data[1];
  assign c         = data[2];
  assign d         = data[3];

endmodule

// File: tb/tb_my_dmux_16_4_way_buf.sv
// tb/tb_my_dmux_16_4_way_buf.sv - scoreboard bench for my_dmux_16_4_way_buf
// Directed scenarios drive the inputs; a negedge monitor tracks accepted words per channel and checks every delivery.
module tb_my_dmux_16_4_way_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = 16'h0;
  logic [1:0]  sel = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a, b, c, d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'b0000;
  logic [15:0] count;

  int total = 0;
  int bad = 0;

  logic [15:0] q [4][$];
  logic [15:0] exp_count = 16'h0;
  logic [15:0] delivered = 16'h0;

  my_dmux_16_4_way_buf #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] chan(input int i);
    case (i)
      0: chan = a;
      1: chan = b;
      2: chan = c;
      default: chan = d;
    endcase
  endfunction

  // Model and monitor: queue depth stands for the expected full flag of each channel.
  always @(negedge clk) begin
    logic [3:0]  exp_valid;
    logic        exp_ready;
    logic [15:0] got;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      exp_count = 16'h0;
      delivered = 16'h0;
      check("mon_rst_valid", {28'h0, out_valid}, 32'h0);
      check("mon_rst_count", {16'h0, count}, 32'h0);
    end else begin
      for (int i = 0; i < 4; i++) exp_valid[i] = (q[i].size() != 0);
      exp_ready = !exp_valid[sel] || out_ready[sel];
      check("mon_out_valid", {28'h0, out_valid}, {28'h0, exp_valid});
      check("mon_count", {16'h0, count}, {16'h0, exp_count});
      check("mon_in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
      for (int i = 0; i < 4; i++) begin
        if (exp_valid[i] && out_ready[i]) begin
          got = chan(i);
          check($sformatf("mon_data_ch%0d", i), {16'h0, got}, {16'h0, q[i][0]});
          void'(q[i].pop_front());
          delivered = delivered + 16'd1;
        end
      end
      if (in_valid && exp_ready) begin
        q[sel].push_back(in);
        exp_count = exp_count + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] w, input logic [1:0] s, input logic v, input logic [3:0] r);
    in = w; sel = s; in_valid = v; out_ready = r;
  endtask

  task automatic do_reset();
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", {28'h0, out_valid}, 32'h0);
    check("rst_abcd", {a, b}, 32'h0);
    check("rst_cd", {c, d}, 32'h0);
    check("rst_count", {16'h0, count}, 32'h0);
    rst_n = 1'b1;

    // Single word to channel c, no consumer
    drive(16'h1234, 2'd2, 1'b1, 4'b0000);
    tick();
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("one_valid", {28'h0, out_valid}, 32'h4);
    check("one_c", {16'h0, c}, 32'h1234);
    check("one_count", {16'h0, count}, 32'h1);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("one_ready_sel%0d", s), {31'h0, in_ready}, (s == 2) ? 32'h0 : 32'h1);
    end

    // Same-edge drain and refill of channel b
    do_reset();
    drive(16'h1111, 2'd1, 1'b1, 4'b0000);
    tick();
    drive(16'hBEEF, 2'd1, 1'b1, 4'b0010);
    #1;
    check("refill_ready", {31'h0, in_ready}, 32'h1);
    tick();
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("refill_valid", {28'h0, out_valid}, 32'h2);
    check("refill_b", {16'h0, b}, 32'hBEEF);
    check("refill_count", {16'h0, count}, 32'h2);
    drive(16'h0, 2'd0, 1'b0, 4'b0010);
    tick();
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("drain_valid", {28'h0, out_valid}, 32'h0);
    check("drain_b_hold", {16'h0, b}, 32'hBEEF);

    // Round robin fill with no consumers, then back-pressure
    do_reset();
    for (int s = 0; s < 4; s++) begin
      drive(16'h000A + 16'(s), 2'(s), 1'b1, 4'b0000);
      tick();
    end
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("rr_valid", {28'h0, out_valid}, 32'hF);
    check("rr_ab", {a, b}, 32'h000A000B);
    check("rr_cd", {c, d}, 32'h000C000D);
    for (int s = 0; s < 4; s++) begin
      drive(16'h0077, 2'(s), 1'b1, 4'b0000);
      #1;
      check($sformatf("rr_full_ready%0d", s), {31'h0, in_ready}, 32'h0);
    end
    drive(16'h0077, 2'd1, 1'b1, 4'b0000);
    tick();
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("rr_count_hold", {16'h0, count}, 32'h4);
    check("rr_b_hold", {16'h0, b}, 32'h000B);

    // Asynchronous reset with all channels full
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {28'h0, out_valid}, 32'h0);
    check("async_ab", {a, b}, 32'h0);
    check("async_cd", {c, d}, 32'h0);
    check("async_count", {16'h0, count}, 32'h0);
    check("async_ready", {31'h0, in_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    drive(16'h5555, 2'd3, 1'b1, 4'b0000);
    tick();
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("post_rst_valid", {28'h0, out_valid}, 32'h8);
    check("post_rst_d", {16'h0, d}, 32'h5555);
    check("post_rst_count", {16'h0, count}, 32'h1);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(16'(i), 2'(i), 1'b1, 4'b1111);
      tick();
    end
    check("wrap_ffff", {16'h0, count}, 32'h0000FFFF);
    drive(16'hABCD, 2'd0, 1'b1, 4'b1111);
    tick();
    drive(16'h0, 2'd0, 1'b0, 4'b1111);
    check("wrap_zero", {16'h0, count}, 32'h0);

    // Random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      drive(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      tick();
    end
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("rand_conserve", {16'h0, 16'(delivered + 16'($countones(out_valid)))}, {16'h0, count});
    drive(16'h0, 2'd0, 1'b0, 4'b1111);
    tick();
    tick();
    drive(16'h0, 2'd0, 1'b0, 4'b0000);
    check("rand_drained", {28'h0, out_valid}, 32'h0);
    check("rand_total", {16'h0, delivered}, {16'h0, count});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
